// File: rtl/cam_power_seq.sv
// Camera sensor power sequencer: pwdn release, reset hold, settle, then ready.
// Define CAM_POWER_SEQ_STANDBY_EN to enable the READY <-> STANDBY power-down path.
module cam_power_seq #(
  parameter int T_PWDN_CYC   = 250000,
  parameter int T_RST_CYC    = 150000,
  parameter int T_SETTLE_CYC = 150000,
  parameter int CNT_W        = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwr_req,
  input  logic       standby_req,
  output logic       cam_pwdn,
  output logic       cam_rst,
  output logic       power_done,
  output logic       busy,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_PWR_UP   = 3'd1,
    S_RST_HOLD = 3'd2,
    S_SETTLE   = 3'd3,
    S_READY    = 3'd4,
    S_STANDBY  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LD_PWDN   = CNT_W'(T_PWDN_CYC - 1);
  localparam logic [CNT_W-1:0] LD_RST    = CNT_W'(T_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(T_SETTLE_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cnt_zero;
  logic             pwdn_nxt, crst_nxt, done_nxt, busy_nxt;

  assign cnt_zero = (cnt == '0);

`ifndef CAM_POWER_SEQ_STANDBY_EN
  logic unused_standby_req;
  assign unused_standby_req = standby_req;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_zero ? '0 : cnt - 1'b1;
    case (state)
      S_OFF: begin
        if (pwr_req) begin
          state_nxt = S_PWR_UP;
          cnt_nxt   = LD_PWDN;
        end
      end
      S_PWR_UP: begin
        if (cnt_zero) begin
          state_nxt = S_RST_HOLD;
          cnt_nxt   = LD_RST;
        end
      end
      S_RST_HOLD: begin
        if (cnt_zero) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = LD_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_zero) begin
          state_nxt = S_READY;
          cnt_nxt   = '0;
        end
      end
      S_READY: begin
`ifdef CAM_POWER_SEQ_STANDBY_EN
        if (standby_req) state_nxt = S_STANDBY;
`endif
      end
      S_STANDBY: begin
`ifdef CAM_POWER_SEQ_STANDBY_EN
        // Leaving standby reruns only the settle delay; the sensor keeps its reset released.
        if (!standby_req) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = LD_SETTLE;
        end
`else
        state_nxt = S_OFF;
        cnt_nxt   = '0;
`endif
      end
      default: begin
        state_nxt = S_OFF;
        cnt_nxt   = '0;
      end
    endcase

    // Losing the power request overrides everything, including a timer expiry.
    if (!pwr_req && state != S_OFF) begin
      state_nxt = S_OFF;
      cnt_nxt   = '0;
    end

    pwdn_nxt = 1'b1;
    crst_nxt = 1'b0;
    done_nxt = 1'b0;
    busy_nxt = 1'b0;
    case (state_nxt)
      S_PWR_UP, S_RST_HOLD: begin
        pwdn_nxt = 1'b0;
        busy_nxt = 1'b1;
      end
      S_SETTLE: begin
        pwdn_nxt = 1'b0;
        crst_nxt = 1'b1;
        busy_nxt = 1'b1;
      end
      S_READY: begin
        pwdn_nxt = 1'b0;
        crst_nxt = 1'b1;
        done_nxt = 1'b1;
      end
      S_STANDBY: begin
        crst_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are decoded from the next state so they flip on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_OFF;
      cnt        <= '0;
      cam_pwdn   <= 1'b1;
      cam_rst    <= 1'b0;
      power_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cam_pwdn   <= pwdn_nxt;
      cam_rst    <= crst_nxt;
      power_done <= done_nxt;
      busy       <= busy_nxt;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_cam_power_seq.sv
// Bench for cam_power_seq: per-cycle scoreboard against a cycle-count model,
// plus latency, abort, async-reset and standby scenarios.
module tb_cam_power_seq;

  localparam int T_PWDN   = 5;
  localparam int T_RST    = 3;
  localparam int T_SETTLE = 4;
  localparam int W        = 7;
`ifdef CAM_POWER_SEQ_STANDBY_EN
  localparam bit STANDBY_ON = 1'b1;
`else
  localparam bit STANDBY_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       pwr_req;
  logic       standby_req;
  logic       cam_pwdn;
  logic       cam_rst;
  logic       power_done;
  logic       busy;
  logic [2:0] state_o;
  logic [W-1:0] dut_vec;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_state  = 0;
  int m_el     = 0;

  cam_power_seq #(
    .T_PWDN_CYC  (T_PWDN),
    .T_RST_CYC   (T_RST),
    .T_SETTLE_CYC(T_SETTLE),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pwr_req    (pwr_req),
    .standby_req(standby_req),
    .cam_pwdn   (cam_pwdn),
    .cam_rst    (cam_rst),
    .power_done (power_done),
    .busy       (busy),
    .state_o    (state_o)
  );

  assign dut_vec = {state_o, cam_pwdn, cam_rst, power_done, busy};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // reference model: counts cycles spent in each timed phase
  task automatic model_reset();
    m_state = 0;
    m_el    = 0;
  endtask

  task automatic model_step(input logic p, input logic s);
    if (m_state != 0 && !p) begin
      m_state = 0;
      m_el    = 0;
    end else begin
      case (m_state)
        0: if (p) begin m_state = 1; m_el = 0; end
        1: if (m_el + 1 >= T_PWDN) begin m_state = 2; m_el = 0; end else m_el++;
        2: if (m_el + 1 >= T_RST) begin m_state = 3; m_el = 0; end else m_el++;
        3: if (m_el + 1 >= T_SETTLE) begin m_state = 4; m_el = 0; end else m_el++;
        4: if (STANDBY_ON && s) m_state = 5;
        5: if (!s) begin m_state = 3; m_el = 0; end
        default: m_state = 0;
      endcase
    end
  endtask

  function automatic logic [W-1:0] model_vec();
    logic pwdn, crst, done, bsy;
    pwdn = (m_state == 0) || (m_state == 5);
    crst = (m_state >= 3);
    done = (m_state == 4);
    bsy  = (m_state >= 1) && (m_state <= 3);
    return {3'(m_state), pwdn, crst, done, bsy};
  endfunction

  // driver: one clock of stimulus, expectation pushed now, compared after the edge
  task automatic cycle(input logic p, input logic s);
    logic [W-1:0] e;
    pwr_req     = p;
    standby_req = s;
    model_step(p, s);
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("seq", 32'(dut_vec), 32'(e));
    end
  endtask

  task automatic run_until_ready(input string tag);
    int rst_lat, done_lat;
    rst_lat  = 0;
    done_lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 1'b0);
      if (cam_rst && rst_lat == 0) rst_lat = i;
      if (power_done && done_lat == 0) done_lat = i;
    end
    check({tag, "_rst_lat"}, 32'(rst_lat), 32'(1 + T_PWDN + T_RST));
    check({tag, "_done_lat"}, 32'(done_lat), 32'(1 + T_PWDN + T_RST + T_SETTLE));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_pwdn"}, 32'(cam_pwdn), 32'd1);
    check({tag, "_crst"}, 32'(cam_rst), 32'd0);
    check({tag, "_done"}, 32'(power_done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int any_done, pwdn_cnt, settle_cnt, crst_low;
    rst         = 1'b1;
    pwr_req     = 1'b0;
    standby_req = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // power-up sequence and its latency
    run_until_ready("pwrup");

    // drop request during RST_HOLD, then full restart
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0);
    check("rsthold_state", 32'(state_o), 32'd2);
    cycle(1'b0, 1'b0);
    check_reset_outputs("abort");
    run_until_ready("restart");

    // one-cycle glitch during PWR_UP restarts from OFF
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    run_until_ready("glitch");

    // request falls on the same cycle the settle timer expires
    cycle(1'b0, 1'b0);
    any_done = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0);
      if (power_done) any_done = 1;
    end
    check("settle_last_state", 32'(state_o), 32'd3);
    cycle(1'b0, 1'b0);
    if (power_done) any_done = 1;
    check("expiry_drop_state", 32'(state_o), 32'd0);
    check("expiry_drop_done", 32'(any_done), 32'd0);

    // standby request pulsed for two cycles in READY
    run_until_ready("pre_sb");
    pwdn_cnt   = 0;
    settle_cnt = 0;
    crst_low   = 0;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1);
      if (cam_pwdn) pwdn_cnt++;
      if (!cam_rst) crst_low = 1;
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0);
      if (state_o == 3'd3) settle_cnt++;
      if (!cam_rst) crst_low = 1;
    end
    cycle(1'b1, 1'b0);
    check("sb_pwdn_cycles", 32'(pwdn_cnt), STANDBY_ON ? 32'd2 : 32'd0);
    check("sb_settle_cycles", 32'(settle_cnt), STANDBY_ON ? 32'd4 : 32'd0);
    check("sb_crst_low", 32'(crst_low), 32'd0);
    check("sb_final_done", 32'(power_done), 32'd1);

    // asynchronous reset in SETTLE
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
    check("pre_arst_state", 32'(state_o), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("arst_async");
    @(posedge clk);
    #1;
    check_reset_outputs("arst_held");
    rst = 1'b0;
    model_reset();
    run_until_ready("post_arst");

    // random request traffic
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 15) != 0, $urandom_range(0, 7) == 0);
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_power_seq.md
CAM_POWER_SEQ -- requirements
Module: cam_power_seq

Interface
REQ-001 Parameter T_PWDN_CYC, default 250000: cycles with sensor powered (pwdn low) before the reset phase starts.
REQ-002 Parameter T_RST_CYC, default 150000: cycles cam_rst is held low.
REQ-003 Parameter T_SETTLE_CYC, default 150000: cycles from cam_rst release (or standby exit) to ready.
REQ-004 Parameter CNT_W, default 25: delay counter width; each T_* value SHALL be in the range 1 .. 2^CNT_W-1.
REQ-005 clk  input  1  single system clock; all logic on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 pwr_req  input  1  level; 1 = sensor powered and sequenced, 0 = sensor off.
REQ-008 standby_req  input  1  level; 1 = enter power-down standby from READY.
REQ-009 cam_pwdn  output  1  sensor power-down pin; 1 = powered down.
REQ-010 cam_rst  output  1  sensor reset pin, active-low; 0 = sensor held in reset.
REQ-011 power_done  output  1  1 = sensor ready for SCCB configuration.
REQ-012 busy  output  1  1 while a timed phase (PWR_UP, RST_HOLD, SETTLE) is running.
REQ-013 state_o  output  3  current state encoding, for debug.

Function
REQ-014 FSM states and encodings: OFF=0, PWR_UP=1, RST_HOLD=2, SETTLE=3, READY=4, STANDBY=5.
REQ-015 OFF: cam_pwdn=1, cam_rst=0, power_done=0; goes to PWR_UP on the first cycle pwr_req=1.
REQ-016 PWR_UP: cam_pwdn=0, cam_rst=0; goes to RST_HOLD after exactly T_PWDN_CYC cycles in the state.
REQ-017 RST_HOLD: cam_pwdn=0, cam_rst=0; goes to SETTLE after exactly T_RST_CYC cycles.
REQ-018 SETTLE: cam_pwdn=0, cam_rst=1; goes to READY after exactly T_SETTLE_CYC cycles.
REQ-019 READY: cam_pwdn=0, cam_rst=1, power_done=1.
REQ-020 The outputs are registered and SHALL change on the same edge as the state change.
REQ-021 One shared down-counter: it loads T_x-1 on entry to each timed state, and the transition fires when the count is 0 while in that state.
REQ-022 The counter SHALL NOT wrap; it holds at 0 in untimed states.
REQ-023 pwr_req=0 in any state except OFF: next cycle goes to OFF; the counter clears.
REQ-024 pwr_req=0 has priority over standby_req and over a timer expiry in the same cycle.
REQ-025 A pwr_req glitch of one cycle during PWR_UP restarts the whole sequence from OFF; no partial resume.
REQ-026 busy=1 exactly in PWR_UP, RST_HOLD and SETTLE.
REQ-027 power_done SHALL never be 1 outside READY.
REQ-028 Latency from the pwr_req rise to power_done=1: 1+T_PWDN_CYC+T_RST_CYC+T_SETTLE_CYC cycles.

Reset
REQ-029 While rst=1: state=OFF, counter=0, cam_pwdn=1, cam_rst=0, power_done=0, busy=0, state_o=0.
REQ-030 rst asserted mid-sequence aborts immediately (asynchronously); after release the sequence restarts from OFF once pwr_req=1.

Configuration
REQ-031 Macro CAM_POWER_SEQ_STANDBY_EN controls standby support.
REQ-032 With CAM_POWER_SEQ_STANDBY_EN defined:
- READY with standby_req=1 goes to STANDBY: cam_pwdn=1, cam_rst=1, power_done=0.
- STANDBY with standby_req=0 goes to SETTLE, which reruns the T_SETTLE_CYC delay with no reset pulse.
REQ-033 Without CAM_POWER_SEQ_STANDBY_EN: standby_req is ignored, STANDBY is unreachable, and state_o never equals 5.

Verification (T_PWDN_CYC=5, T_RST_CYC=3, T_SETTLE_CYC=4)
REQ-034 rst pulse, then pwr_req=1 held -> state 0->1->2->3->4; cam_rst rises 9 cycles after pwr_req; power_done rises after 13 cycles.
REQ-035 pwr_req dropped during RST_HOLD -> next cycle OFF, cam_pwdn=1, cam_rst=0, busy=0; pwr_req reasserted -> full 13-cycle sequence.
REQ-036 rst asserted in SETTLE -> outputs reach reset values before the next clock edge; no spurious power_done.
REQ-037 STANDBY_EN defined, standby_req pulsed 2 cycles in READY -> cam_pwdn=1 for 2 cycles, then SETTLE for 4 cycles, then READY; cam_rst stays 1 throughout.
REQ-038 STANDBY_EN undefined, same stimulus -> READY held, power_done stays 1.
REQ-039 pwr_req falls in the same cycle as the SETTLE expiry -> OFF; power_done never asserted.
